// File: rtl/sa_pkg.sv
// Shared constants, state encoding and row-select helper for the systolic
// array tile sequencer.
package sa_pkg;

  localparam int N      = 16;           // lanes / accumulator rows
  localparam int DW     = 8;            // data and weight element width
  localparam int ACC_W  = 32;           // accumulator width per row element
  localparam int AW     = 8;            // operand buffer address width
  localparam int RW     = $clog2(N);    // row index width
  localparam int LANE_W = N * DW;       // one full operand vector
  localparam int ROW_W  = N * ACC_W;    // one full accumulator row
  localparam int FC_W   = AW + 2;       // fire counter, holds up to 2^AW + 2N - 2

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_SEL   = 3'd3,
    S_CAPT  = 3'd4,
    S_HOLD  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  // Active-low one-cold row select for the array CEN bus.
  function automatic logic [N-1:0] row_sel_n(input logic [RW-1:0] r);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    row_sel_n = ~(one << r);
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// N-lane triangular delay line: lane i sees its input i+1 clocks later
// (one input register plus i skew stages). Invalid input cycles load zero
// so lanes carry 0 outside the valid diagonal.
module sa_skew_line
  import sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [LANE_W-1:0] in_vec,
  output logic [LANE_W-1:0] out_vec
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] pipe [0:i];

    // Shift lane i through its i+1 registers, zero-filling on invalid cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) pipe[k] <= {DW{1'b0}};
      end else begin
        pipe[0] <= in_vld ? in_vec[i*DW +: DW] : {DW{1'b0}};
        for (int k = 1; k <= i; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign out_vec[i*DW +: DW] = pipe[i];
  end

endmodule

// File: rtl/sa_tile_ctrl.sv
// Tile sequencer for the 16x16 systolic array: streams K operand vectors
// with diagonal skew, holds fire through compute and flush, then drains the
// accumulator rows one at a time onto a valid/ready port.
module sa_tile_ctrl
  import sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW:0]       k_len,
  output logic              busy,
  output logic              done,
  output logic              buf_ren,
  output logic [AW-1:0]     buf_raddr,
  input  logic [LANE_W-1:0] buf_data,
  input  logic [LANE_W-1:0] buf_weight,
  output logic              sa_fire,
  output logic [LANE_W-1:0] sa_data,
  output logic [LANE_W-1:0] sa_weight,
  output logic [N-1:0]      sa_cen,
  input  logic [ROW_W-1:0]  sa_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic [RW-1:0]     out_row
);

  state_t          state_r, state_n;
  logic [AW:0]     k_r, k_n;
  logic [RW-1:0]   row_r, row_n;
  logic            rd_vld_r;
  logic [FC_W-1:0] fire_cnt_r;
  logic [FC_W-1:0] fire_last_s;
  logic [AW:0]     last_addr_s;
  logic            ren_n, valid_n, done_n, capt_s;
  logic [AW-1:0]   raddr_n;
  logic [N-1:0]    cen_n;

  // Fire spans K + 2N - 1 cycles: counter runs 0 .. K + 2N - 2.
  assign fire_last_s = {1'b0, k_r} + FC_W'(2 * N - 2);
  assign last_addr_s = k_r - (AW + 1)'(1);

  sa_skew_line u_skew_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_vld_r),
    .in_vec  (buf_data),
    .out_vec (sa_data)
  );

  sa_skew_line u_skew_weight (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_vld_r),
    .in_vec  (buf_weight),
    .out_vec (sa_weight)
  );

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_n = state_r;
    k_n     = k_r;
    row_n   = row_r;
    ren_n   = 1'b0;
    raddr_n = buf_raddr;
    cen_n   = {N{1'b1}};
    valid_n = out_valid;
    done_n  = 1'b0;
    capt_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && (k_len == {(AW + 1){1'b0}})) begin
          state_n = S_FIN;
          done_n  = 1'b1;
        end else if (start) begin
          state_n = S_FEED;
          k_n     = k_len;
          row_n   = {RW{1'b0}};
          ren_n   = 1'b1;
          raddr_n = {AW{1'b0}};
        end else begin
          state_n = S_IDLE;
        end
      end
      S_FEED: begin
        if ({1'b0, buf_raddr} == last_addr_s) begin
          state_n = S_FLUSH;
          raddr_n = {AW{1'b0}};
        end else begin
          ren_n   = 1'b1;
          raddr_n = buf_raddr + AW'(1);
        end
      end
      S_FLUSH: begin
        if (sa_fire && (fire_cnt_r == fire_last_s)) begin
          state_n = S_SEL;
          cen_n   = row_sel_n(row_r);
        end else begin
          state_n = S_FLUSH;
        end
      end
      S_SEL: begin
        state_n = S_CAPT;
        cen_n   = row_sel_n(row_r);
      end
      S_CAPT: begin
        state_n = S_HOLD;
        capt_s  = 1'b1;
        valid_n = 1'b1;
      end
      S_HOLD: begin
        if (out_ready && (row_r == RW'(N - 1))) begin
          valid_n = 1'b0;
          state_n = S_FIN;
          done_n  = 1'b1;
        end else if (out_ready) begin
          valid_n = 1'b0;
          row_n   = row_r + RW'(1);
          state_n = S_SEL;
          cen_n   = row_sel_n(row_r + RW'(1));
        end else begin
          state_n = S_HOLD;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, latched tile parameters and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      k_r       <= {(AW + 1){1'b0}};
      row_r     <= {RW{1'b0}};
      rd_vld_r  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      buf_ren   <= 1'b0;
      buf_raddr <= {AW{1'b0}};
      sa_cen    <= {N{1'b1}};
      out_valid <= 1'b0;
      out_data  <= {ROW_W{1'b0}};
      out_row   <= {RW{1'b0}};
    end else begin
      state_r   <= state_n;
      k_r       <= k_n;
      row_r     <= row_n;
      rd_vld_r  <= buf_ren;
      busy      <= (state_n != S_IDLE);
      done      <= done_n;
      buf_ren   <= ren_n;
      buf_raddr <= raddr_n;
      sa_cen    <= cen_n;
      out_valid <= valid_n;
      if (capt_s) begin
        out_data <= sa_q;
        out_row  <= row_r;
      end
    end
  end

  // Fire rises with the first skewed element on lane 0 and is held for
  // exactly K + 2N - 1 cycles so every diagonal drains through the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_fire    <= 1'b0;
      fire_cnt_r <= {FC_W{1'b0}};
    end else if (state_r == S_IDLE) begin
      sa_fire    <= 1'b0;
      fire_cnt_r <= {FC_W{1'b0}};
    end else if (sa_fire) begin
      if (fire_cnt_r == fire_last_s) begin
        sa_fire <= 1'b0;
      end else begin
        fire_cnt_r <= fire_cnt_r + FC_W'(1);
      end
    end else if (rd_vld_r && (fire_cnt_r == {FC_W{1'b0}})) begin
      sa_fire <= 1'b1;
    end
  end

endmodule
